fmap_bank_buf: RTL

Parametrised multi-channel feature-map buffer: CH parallel banks of DEPTH x DATA_W words, written in parallel (one word per channel per cycle) by the pooling/conv stage. It supports two read modes. The first is random single-word reads (channel select + address, fixed 2-cycle latency). The second is an autonomous flatten stream that emits all channels channel-major with valid/ready backpressure, feeding the fully-connected stage. It is the generalised successor of the fixed 16-channel layer buffers.

---
 rtl/fmap_bank_buf_if.sv | 20 ++
 rtl/fmap_bank_buf.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fmap_bank_buf_if.sv
// fmap_bank_buf stream output bundle: out_valid/out_data/out_last
// toward the consumer, out_ready back. master = buffer, slave = consumer.
interface fmap_bank_buf_if #(
  parameter int DATA_W = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/fmap_bank_buf.sv
// fmap_bank_buf: CH banks of DEPTH x DATA_W, parallel write, 2-cycle
// random read and a channel-major flatten stream with skid FIFO.
// Ports: clk, rst (sync, high); wr_en/wr_addr/wr_data parallel write;
// rd_en/rd_sel/rd_addr -> rd_valid/rd_data; st_start/st_len start a
// stream, busy/done status; st (fmap_bank_buf_if.master) beat output.
// Option: FMAP_BUF_RELU_EN clamps negative output words to zero.
module fmap_bank_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int CH     = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int SW     = $clog2(CH),
  parameter int FIFO_D = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [CH*DATA_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [SW-1:0]      rd_sel,
  input  logic [AW-1:0]      rd_addr,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               st_start,
  input  logic [AW:0]        st_len,
  output logic               busy,
  output logic               done,
  fmap_bank_buf_if.master    st
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  localparam int PW = $clog2(FIFO_D);
  localparam int CW = $clog2(FIFO_D + 1);

  localparam logic [AW:0]   LMAX    = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] CH_LAST = SW'(CH - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(FIFO_D - 1);
  localparam logic [CW:0]   FD      = (CW+1)'(FIFO_D);

  function automatic logic [DATA_W-1:0] relu(
    input logic [DATA_W-1:0] d
  );
`ifdef FMAP_BUF_RELU_EN
    return d[DATA_W-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  function automatic logic [PW-1:0] p_inc(
    input logic [PW-1:0] p
  );
    return (p == P_LAST) ? '0 : p + PW'(1);
  endfunction

  logic [1:0]        state;
  logic [AW:0]       len_q;
  logic [AW-1:0]     a_q;
  logic [SW-1:0]     ch_q;

  logic              s1_rd;
  logic              s1_st;
  logic              s1_last;
  logic [SW-1:0]     s1_sel;

  logic [DATA_W-1:0] mem    [CH][DEPTH];
  logic [DATA_W-1:0] bank_q [CH];

  logic [DATA_W-1:0] f_data [FIFO_D];
  logic              f_last [FIFO_D];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [CW-1:0]     cnt;

  logic              rd_go;
  logic              issue;
  logic              a_end;
  logic              ch_end;
  logic              push;
  logic              pop;
  logic [AW-1:0]     raddr;
  logic [DATA_W-1:0] mux_d;

  assign busy   = (state != S_IDLE);
  assign rd_go  = rd_en & ~busy;
  assign a_end  = ({1'b0, a_q} == len_q - (AW+1)'(1));
  assign ch_end = (ch_q == CH_LAST);

  // Credit check counts the read already in stage 1 so the FIFO
  // can never overflow even if the consumer stalls right now.
  assign issue = (state == S_STREAM) &&
                 (({1'b0, cnt} + {{CW{1'b0}}, s1_st}) < FD);

  // Random reads only use the port while idle, the stream only
  // while busy, so one shared read port suffices.
  assign raddr = busy ? a_q : rd_addr;
  assign mux_d = relu(bank_q[s1_sel]);

  assign push = s1_st;
  assign pop  = st.out_valid & st.out_ready;

  assign st.out_valid = (cnt != '0);
  assign st.out_data  = st.out_valid ? f_data[rp] : '0;
  assign st.out_last  = st.out_valid & f_last[rp];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < CH; c++) begin
        mem[c][wr_addr] <= wr_data[c*DATA_W +: DATA_W];
      end
    end
    if (rd_go | issue) begin
      for (int c = 0; c < CH; c++) begin
        bank_q[c] <= mem[c][raddr];
      end
    end
    if (push) begin
      f_data[wp] <= mux_d;
      f_last[wp] <= s1_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      len_q    <= '0;
      a_q      <= '0;
      ch_q     <= '0;
      s1_rd    <= 1'b0;
      s1_st    <= 1'b0;
      s1_last  <= 1'b0;
      s1_sel   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
    end else begin
      done    <= 1'b0;
      s1_rd   <= rd_go;
      s1_st   <= issue;
      s1_last <= issue & a_end & ch_end;
      s1_sel  <= busy ? ch_q : rd_sel;

      rd_valid <= s1_rd;
      if (s1_rd) rd_data <= mux_d;

      if (push) wp <= p_inc(wp);
      if (pop)  rp <= p_inc(rp);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase

      case (state)
        S_IDLE: begin
          if (st_start) begin
            if (st_len == '0) begin
              done <= 1'b1;
            end else begin
              len_q <= (st_len > LMAX) ? LMAX : st_len;
              a_q   <= '0;
              ch_q  <= '0;
              state <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (issue) begin
            if (a_end) begin
              a_q <= '0;
              if (ch_end) state <= S_DRAIN;
              else        ch_q  <= ch_q + SW'(1);
            end else begin
              a_q <= a_q + AW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (pop & st.out_last) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
